// File: rtl/dmem_if.sv
// Processor-side dmem port: independent load and store channels
// plus the responder's status outputs.
interface dmem_if;
  logic [63:0] dmem_addressLoad;
  logic        dmem_readEn;
  logic [63:0] dmem_addressStore;
  logic        dmem_writeEn;
  logic [63:0] dmem_WriteData;
  logic [3:0]  xfer_size;
  logic [63:0] dmem_readData;
  logic        sb_busy_o;
  logic        misaligned_o;
  logic        overflow_o;

  modport master (
    output dmem_addressLoad, dmem_readEn,
    output dmem_addressStore, dmem_writeEn,
    output dmem_WriteData, xfer_size,
    input  dmem_readData, sb_busy_o,
    input  misaligned_o, overflow_o
  );

  modport slave (
    input  dmem_addressLoad, dmem_readEn,
    input  dmem_addressStore, dmem_writeEn,
    input  dmem_WriteData, xfer_size,
    output dmem_readData, sb_busy_o,
    output misaligned_o, overflow_o
  );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: 1-cycle loads, in-order store buffer with
// load forwarding, draining into a 64-bit array (RMW for sub-words).
module dmem_responder #(
  parameter int ADDR_BITS = 10,
  parameter int SB_DEPTH  = 4
) (
  input logic clk,
  input logic reset,
  dmem_if.slave bus
);
  localparam int IDX_W = ADDR_BITS - 3;
  localparam int WORDS = 1 << IDX_W;
  localparam int SB_W  = $clog2(SB_DEPTH);
  localparam int PTR_W = SB_W + 1;

  localparam logic [0:0] S_IDLE   = 1'b0;
  localparam logic [0:0] S_RMW_WR = 1'b1;

  logic [63:0]      mem_q [WORDS];
  logic [IDX_W-1:0] sb_idx_q [SB_DEPTH];
  logic [7:0]       sb_be_q [SB_DEPTH];
  logic [63:0]      sb_data_q [SB_DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [0:0]       state_q, state_d;
  logic [63:0]      rmw_q, rmw_d;
  logic [63:0]      rdata_q, rdata_d;
  logic             mis_q, mis_d;
  logic             ovf_q, ovf_d;

  logic [3:0]       sz;
  logic [2:0]       szm;
  logic [7:0]       low_be;
  logic [2:0]       ld_lane, st_lane;
  logic [IDX_W-1:0] ld_idx, st_idx;
  logic             ld_mis, st_mis;
  logic [7:0]       st_be;
  logic [63:0]      st_data;
  logic [SB_W-1:0]  head, tail, slot;
  logic [PTR_W-1:0] count;
  logic             empty, full;
  logic [63:0]      fwd;
  logic             pop, enq, drop;
  logic             mem_we;
  logic [IDX_W-1:0] mem_widx;
  logic [63:0]      mem_wdata;
  logic             unused_bits;

  assign unused_bits = ^{bus.dmem_addressLoad[63:ADDR_BITS],
                         bus.dmem_addressStore[63:ADDR_BITS]};

  function automatic logic [3:0] eff_size(input logic [3:0] s);
    case (s)
      4'd1, 4'd2, 4'd4: return s;
      default:          return 4'd8;
    endcase
  endfunction

  function automatic logic [63:0] expand(input logic [7:0] be);
    logic [63:0] m;
    for (int b = 0; b < 8; b++) m[b*8 +: 8] = {8{be[b]}};
    return m;
  endfunction

  function automatic logic [63:0] merge(
    input logic [63:0] old,
    input logic [7:0]  be,
    input logic [63:0] data
  );
    return (old & ~expand(be)) | (data & expand(be));
  endfunction

  always_comb begin
    sz      = eff_size(bus.xfer_size);
    szm     = sz[2:0] - 3'd1;
    low_be  = 8'hFF >> (4'd8 - sz);
    ld_lane = bus.dmem_addressLoad[2:0];
    ld_idx  = bus.dmem_addressLoad[ADDR_BITS-1:3];
    ld_mis  = |(ld_lane & szm);
    st_lane = bus.dmem_addressStore[2:0];
    st_idx  = bus.dmem_addressStore[ADDR_BITS-1:3];
    st_mis  = |(st_lane & szm);
    st_be   = low_be << st_lane;
    st_data = (bus.dmem_WriteData << {st_lane, 3'b000})
              & expand(st_be);
    head    = rd_ptr_q[SB_W-1:0];
    tail    = wr_ptr_q[SB_W-1:0];
    count   = wr_ptr_q - rd_ptr_q;
    empty   = (wr_ptr_q == rd_ptr_q);
    full    = (wr_ptr_q[SB_W-1:0] == rd_ptr_q[SB_W-1:0])
              && (wr_ptr_q[SB_W] != rd_ptr_q[SB_W]);
  end

  // Buffered stores overlay the array word oldest to youngest.
  always_comb begin
    fwd  = mem_q[ld_idx];
    slot = '0;
    for (int i = 0; i < SB_DEPTH; i++) begin
      slot = head + SB_W'(i);
      if (PTR_W'(i) < count && sb_idx_q[slot] == ld_idx)
        fwd = merge(fwd, sb_be_q[slot], sb_data_q[slot]);
    end
  end

  always_comb begin
    state_d   = state_q;
    rmw_d     = rmw_q;
    pop       = 1'b0;
    mem_we    = 1'b0;
    mem_widx  = sb_idx_q[head];
    mem_wdata = sb_data_q[head];
    unique case (1'b1)
      (state_q == S_IDLE): begin
        if (!empty) begin
          if (&sb_be_q[head]) begin
            mem_we = 1'b1;
            pop    = 1'b1;
          end else if (!bus.dmem_readEn) begin
            rmw_d   = mem_q[sb_idx_q[head]];
            state_d = S_RMW_WR;
          end
        end
      end
      (state_q == S_RMW_WR): begin
        mem_we    = 1'b1;
        mem_wdata = merge(rmw_q, sb_be_q[head], sb_data_q[head]);
        pop       = 1'b1;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    enq      = bus.dmem_writeEn && !st_mis && (!full || pop);
    drop     = bus.dmem_writeEn && !st_mis && full && !pop;
    wr_ptr_d = wr_ptr_q + PTR_W'(enq);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    ovf_d    = ovf_q | drop;
    mis_d    = (bus.dmem_readEn && ld_mis)
               || (bus.dmem_writeEn && st_mis);
    rdata_d  = rdata_q;
    if (bus.dmem_readEn)
      rdata_d = ld_mis ? 64'd0
              : (fwd >> {ld_lane, 3'b000}) & expand(low_be);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      state_q  <= S_IDLE;
      rmw_q    <= '0;
      rdata_q  <= '0;
      mis_q    <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      state_q  <= state_d;
      rmw_q    <= rmw_d;
      rdata_q  <= rdata_d;
      mis_q    <= mis_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage needs no reset; validity lives in the pointers.
  always_ff @(posedge clk) begin
    if (!reset && enq) begin
      sb_idx_q[tail]  <= st_idx;
      sb_be_q[tail]   <= st_be;
      sb_data_q[tail] <= st_data;
    end
    if (!reset && mem_we)
      mem_q[mem_widx] <= mem_wdata;
  end

  assign bus.dmem_readData = rdata_q;
  assign bus.sb_busy_o     = !empty;
  assign bus.misaligned_o  = mis_q;
  assign bus.overflow_o    = ovf_q;
endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed vector table, then random
// traffic against a byte-level memory/queue reference model.
module tb_dmem_responder;
  localparam int AB    = 10;
  localparam int DEPTH = 4;
  localparam int MEMB  = 1 << AB;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  dmem_if bus();

  dmem_responder #(.ADDR_BITS(AB), .SB_DEPTH(DEPTH)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  typedef struct {
    int          addr;
    int          sz;
    logic [63:0] data;
  } st_t;

  typedef struct {
    bit          rst;
    bit          re;
    logic [63:0] la;
    bit          we;
    logic [63:0] sa;
    logic [63:0] wd;
    logic [3:0]  sz;
    logic [3:0]  chk;
    logic [63:0] e_rd;
    bit          e_busy;
    bit          e_mis;
    bit          e_ovf;
  } vec_t;

  st_t         q[$];
  logic [7:0]  arr [MEMB];
  bit          armed;
  logic [63:0] m_rd;
  bit          m_mis;
  bit          m_ovf;
  vec_t        tbl[$];
  int          vectors = 0;
  int          miscompares = 0;

  function automatic logic [63:0] pat(input int w);
    return {32'hA5A50000 + 32'(w), 32'h5A5A0000 + 32'(w)};
  endfunction

  function automatic int eff(input logic [3:0] s);
    return (s == 1 || s == 2 || s == 4) ? int'(s) : 8;
  endfunction

  // What the processor should see: array bytes overlaid by pending stores.
  function automatic logic [7:0] view_byte(input int a);
    logic [7:0] b = arr[a];
    foreach (q[i])
      for (int k = 0; k < q[i].sz; k++)
        if (q[i].addr + k == a) b = q[i].data[8*k +: 8];
    return b;
  endfunction

  task automatic check(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic model(input bit rst, input bit re, input logic [63:0] la,
                       input bit we, input logic [63:0] sa,
                       input logic [63:0] wd, input logic [3:0] szi);
    int s, la_a, sa_a;
    bit pop;
    if (rst) begin
      q.delete();
      armed = 0; m_rd = '0; m_mis = 0; m_ovf = 0;
      return;
    end
    s    = eff(szi);
    la_a = int'(la[AB-1:0]);
    sa_a = int'(sa[AB-1:0]);
    if (re) begin
      m_rd = '0;
      if (la_a % s == 0)
        for (int k = 0; k < s; k++) m_rd[8*k +: 8] = view_byte(la_a + k);
    end
    pop = 0;
    if (armed) begin
      pop = 1; armed = 0;
    end else if (q.size() > 0) begin
      if (q[0].sz == 8) pop = 1;
      else if (!re) armed = 1;
    end
    if (pop) begin
      for (int k = 0; k < q[0].sz; k++)
        arr[q[0].addr + k] = q[0].data[8*k +: 8];
      void'(q.pop_front());
    end
    if (we && sa_a % s == 0) begin
      if (q.size() < DEPTH) q.push_back('{sa_a, s, wd});
      else m_ovf = 1;
    end
    m_mis = (re && la_a % s != 0) || (we && sa_a % s != 0);
  endtask

  task automatic step(input bit rst, input bit re, input logic [63:0] la,
                      input bit we, input logic [63:0] sa,
                      input logic [63:0] wd, input logic [3:0] szi);
    reset                 = rst;
    bus.dmem_readEn       = re;
    bus.dmem_addressLoad  = la;
    bus.dmem_writeEn      = we;
    bus.dmem_addressStore = sa;
    bus.dmem_WriteData    = wd;
    bus.xfer_size         = szi;
    model(rst, re, la, we, sa, wd, szi);
    @(posedge clk);
    #1;
    check("model rdata", bus.dmem_readData, m_rd);
    check("model busy", 64'(bus.sb_busy_o), 64'(q.size() != 0));
    check("model misaligned", 64'(bus.misaligned_o), 64'(m_mis));
    check("model overflow", 64'(bus.overflow_o), 64'(m_ovf));
  endtask

  task automatic addv(input bit rst, input bit re, input logic [63:0] la,
                      input bit we, input logic [63:0] sa,
                      input logic [63:0] wd, input logic [3:0] szi,
                      input logic [3:0] chk, input logic [63:0] e_rd,
                      input bit eb, input bit em, input bit eo);
    tbl.push_back('{rst, re, la, we, sa, wd, szi, chk, e_rd, eb, em, eo});
  endtask

  task automatic idle(input logic [3:0] chk, input bit eb,
                      input bit em, input bit eo);
    addv(0, 0, 0, 0, 0, 0, 8, chk, 0, eb, em, eo);
  endtask

  function automatic logic [63:0] rand_addr();
    logic [63:0] a = {$urandom, $urandom};
    if ($urandom_range(0, 7) != 0)
      a[AB-1:0] = 10'h180 + 10'($urandom_range(0, 63));
    return a;
  endfunction

  function automatic logic [3:0] rand_size();
    case ($urandom_range(0, 9))
      0, 1:    return 4'd1;
      2, 3:    return 4'd2;
      4, 5:    return 4'd4;
      6, 7:    return 4'd8;
      8:       return 4'd0;
      default: return 4'($urandom_range(0, 15));
    endcase
  endfunction

  initial begin
    armed = 0; m_rd = '0; m_mis = 0; m_ovf = 0;
    foreach (arr[i]) arr[i] = '0;

    step(1, 0, 0, 0, 0, 0, 8);
    step(1, 0, 0, 0, 0, 0, 8);
    check("reset rdata", bus.dmem_readData, 64'd0);
    check("reset busy", 64'(bus.sb_busy_o), 64'd0);
    check("reset misaligned", 64'(bus.misaligned_o), 64'd0);
    check("reset overflow", 64'(bus.overflow_o), 64'd0);

    for (int w = 0; w < MEMB / 8; w++)
      step(0, 0, 0, 1, 64'(w * 8), pat(w), 8);
    step(0, 0, 0, 0, 0, 0, 8);
    step(0, 0, 0, 0, 0, 0, 8);

    // chk bits: [0] rdata, [1] busy, [2] misaligned, [3] overflow
    addv(0, 0, 0, 1, 'h10, 'h1122334455667788, 8, 4'b0010, 0, 1, 0, 0);
    addv(0, 1, 'h10, 0, 0, 0, 8, 4'b0011, 'h1122334455667788, 0, 0, 0);
    addv(0, 0, 0, 1, 'h10, 0, 8, 4'b0010, 0, 1, 0, 0);
    addv(0, 1, 'h40, 1, 'h13, 'hAB, 1, 4'b0010, 0, 1, 0, 0);
    for (int i = 0; i < 4; i++)
      addv(0, 1, 'h40, 0, 0, 0, 8, 4'b0010, 0, 1, 0, 0);
    addv(0, 1, 'h10, 0, 0, 0, 8, 4'b0011, 'h00000000AB000000, 1, 0, 0);
    idle(4'b0010, 1, 0, 0);
    idle(4'b0010, 0, 0, 0);
    addv(0, 0, 0, 1, 'h20, 5, 8, 4'b0010, 0, 1, 0, 0);
    idle(4'b0010, 0, 0, 0);
    addv(0, 1, 'h20, 1, 'h20, 'h77, 8, 4'b0011, 5, 1, 0, 0);
    addv(0, 1, 'h20, 0, 0, 0, 8, 4'b0011, 'h77, 0, 0, 0);
    for (int i = 0; i < 5; i++)
      addv(0, 1, 'h40, 1, 64'('h100 + i), 64'('h10 + i), 1,
           4'b1010, 0, 1, 0, i == 4);
    for (int i = 0; i < 7; i++) idle(4'b1000, 0, 0, 1);
    idle(4'b1010, 0, 0, 1);
    addv(0, 1, 'h06, 0, 0, 0, 4, 4'b0101, 0, 0, 1, 0);
    addv(0, 0, 0, 1, 'h03, 'hFFFF, 2, 4'b0110, 0, 0, 1, 0);
    idle(4'b0100, 0, 0, 0);
    addv(0, 1, 'h00, 0, 0, 0, 8, 4'b0001, pat(0), 0, 0, 0);
    addv(0, 1, 'h40, 1, 'h200, 'hEE, 1, 4'b0010, 0, 1, 0, 0);
    addv(0, 1, 'h40, 1, 'h208, 'hDD, 1, 4'b0010, 0, 1, 0, 0);
    addv(0, 1, 'h40, 1, 'h211, 'hCC, 1, 4'b0010, 0, 1, 0, 0);
    idle(4'b1010, 1, 0, 1);
    addv(1, 0, 0, 0, 0, 0, 8, 4'b1111, 0, 0, 0, 0);
    idle(4'b0010, 0, 0, 0);
    addv(0, 1, 'h200, 0, 0, 0, 8, 4'b0001, pat(64), 0, 0, 0);
    addv(0, 1, 'h208, 0, 0, 0, 8, 4'b0001, pat(65), 0, 0, 0);
    addv(0, 1, 'h210, 0, 0, 0, 8, 4'b0001, pat(66), 0, 0, 0);

    foreach (tbl[i]) begin
      step(tbl[i].rst, tbl[i].re, tbl[i].la, tbl[i].we,
           tbl[i].sa, tbl[i].wd, tbl[i].sz);
      if (tbl[i].chk[0])
        check($sformatf("vec%0d rdata", i), bus.dmem_readData,
              tbl[i].e_rd);
      if (tbl[i].chk[1])
        check($sformatf("vec%0d busy", i), 64'(bus.sb_busy_o),
              64'(tbl[i].e_busy));
      if (tbl[i].chk[2])
        check($sformatf("vec%0d misaligned", i), 64'(bus.misaligned_o),
              64'(tbl[i].e_mis));
      if (tbl[i].chk[3])
        check($sformatf("vec%0d overflow", i), 64'(bus.overflow_o),
              64'(tbl[i].e_ovf));
    end

    for (int c = 0; c < 3000; c++) begin
      int  p;
      bit  r, re, we;
      p  = ((c / 64) % 2 == 1) ? 85 : 30;
      r  = ($urandom_range(0, 299) == 0);
      re = ($urandom_range(0, 99) < p);
      we = ($urandom_range(0, 99) < 60);
      step(r, re, rand_addr(), we, rand_addr(),
           {$urandom, $urandom}, rand_size());
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end
endmodule
